snoop_bus_ctrl: RTL and testbench

- Sequencer and arbiter for the shared snooping bus between NPROC per-processor caches.
- Accepts one pending instruction per processor and picks one by round-robin.
- Drives the broadcast `instruction` word and the 4-phase `step` sequence (00,01,10,11) that all caches react to.
- Builds the registered InBus from cache OutBus words and owns the 8x4-bit backing memory that supplies data on read misses and absorbs write-backs.

---
 rtl/snoop_bus_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_snoop_bus_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_ctrl.sv
// snoop_bus_ctrl: sequencer/arbiter for the shared snooping bus.
//   Picks one pending per-processor instruction by round-robin, then walks the
//   4-phase step sequence 00,01,10,11 that all caches react to. It builds the
//   registered InBus from cache OutBus words and owns the 8x4-bit backing memory.
// Ports:
//   clock, resetn          - clock (rising edge), async active-low reset
//   req / instr_in         - per-processor request and {op,id,tag,data} word
//   grant                  - one-hot 1-cycle pulse in the S0 cycle of the winner
//   step / instruction     - phase and latched instruction broadcast
//   cache_out / in_bus     - cache OutBus words in, InBus {type,tag,data} out
//   busy, done, err        - op in flight, S3 pulse, sticky multi-writeback error
//   stat_miss, stat_wb     - counters, built only with SNOOP_BUS_STATS_EN defined
module snoop_bus_ctrl #(
    parameter int         NPROC      = 2,
    parameter logic [1:0] INVALIDATE = 2'b00,
    parameter logic [1:0] READ_MISS  = 2'b01,
    parameter logic [1:0] WRITE_BACK = 2'b10,
    parameter logic [1:0] READ_HIT   = 2'b11
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [NPROC-1:0]    req,
    input  logic [10*NPROC-1:0] instr_in,
    output logic [NPROC-1:0]    grant,
    output logic [1:0]          step,
    output logic [9:0]          instruction,
    input  logic [9*NPROC-1:0]  cache_out,
    output logic [8:0]          in_bus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [15:0]         stat_miss,
    output logic [15:0]         stat_wb
);

    typedef enum logic [2:0] {IDLE, S0, S1, S2, S3} state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [1:0]       r_owner;
    logic [NPROC-1:0] r_grant;
    logic [1:0]       r_step;
    logic [9:0]       r_instr;
    logic [8:0]       r_bus;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [3:0]       r_mem [8];

    logic             w_pick_vld;
    logic [1:0]       w_pick;
    logic [9:0]       w_pick_raw;
    int               w_dist;
    int               w_best;
    logic             w_wb_vld;
    logic             w_wb_multi;
    logic [8:0]       w_wb_word;
    logic [8:0]       w_req_word;
    logic [8:0]       w_slot;
    logic             w_wb_absorb;
    logic [8:0]       w_miss_word;
    logic             w_unused;

    // Round-robin: smallest forward distance from the pointer wins.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick     = 2'b00;
        w_pick_raw = '0;
        w_dist     = 0;
        w_best     = NPROC;
        for (int p = 0; p < NPROC; p++) begin
            w_dist = (p + NPROC - int'(r_ptr)) % NPROC;
            if (req[p] && (w_dist < w_best)) begin
                w_best     = w_dist;
                w_pick_vld = 1'b1;
                w_pick     = 2'(p);
                w_pick_raw = instr_in[10*p +: 10];
            end
        end
    end

    // Write-back scan: lowest index wins; in S2 the requester's own word is ignored.
    always_comb begin
        w_wb_vld   = 1'b0;
        w_wb_multi = 1'b0;
        w_wb_word  = '0;
        w_req_word = '0;
        w_slot     = '0;
        for (int p = 0; p < NPROC; p++) begin
            w_slot = cache_out[9*p +: 9];
            if (2'(p) == r_owner)
                w_req_word = w_slot;
            if ((w_slot[8:7] == WRITE_BACK) && !((r_state == S2) && (2'(p) == r_owner))) begin
                if (w_wb_vld) begin
                    w_wb_multi = 1'b1;
                end else begin
                    w_wb_vld  = 1'b1;
                    w_wb_word = w_slot;
                end
            end
        end
    end

    assign w_wb_absorb = w_wb_vld && ((r_state == S0) || (r_state == S2));
    assign w_miss_word = {READ_MISS, r_bus[6:4], r_mem[r_bus[6:4]]};
    // The winner's id field is replaced by its slot number; INVALIDATE only
    // ever passes through from the requester's OutBus.
    assign w_unused    = ^{w_pick_raw[8:7], INVALIDATE};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_ptr   <= 2'b00;
            r_owner <= 2'b00;
            r_grant <= '0;
            r_step  <= 2'b11;
            r_instr <= 10'b0_11_000_0000;
            r_bus   <= {READ_HIT, 7'b0};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < 8; i++)
                r_mem[i] <= 4'h0;
        end else begin
            r_grant <= '0;
            r_done  <= 1'b0;
            if (w_wb_absorb && w_wb_multi)
                r_err <= 1'b1;
            case (r_state)
                IDLE, S3: begin
                    if (w_pick_vld) begin
                        for (int p = 0; p < NPROC; p++)
                            r_grant[p] <= (2'(p) == w_pick);
                        r_instr <= {w_pick_raw[9], w_pick, w_pick_raw[6:0]};
                        r_owner <= w_pick;
                        r_ptr   <= (w_pick == 2'(NPROC-1)) ? 2'b00 : w_pick + 2'b01;
                        r_step  <= 2'b00;
                        r_busy  <= 1'b1;
                        r_state <= S0;
                    end else begin
                        r_step  <= 2'b11;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                S0: begin
                    if (w_wb_vld)
                        r_mem[w_wb_word[6:4]] <= w_wb_word[3:0];
                    r_bus   <= {READ_HIT, 7'b0};
                    r_step  <= 2'b01;
                    r_state <= S1;
                end
                S1: begin
                    r_bus   <= w_req_word;
                    r_step  <= 2'b10;
                    r_state <= S2;
                end
                S2: begin
                    if (w_wb_vld) begin
                        r_mem[w_wb_word[6:4]] <= w_wb_word[3:0];
                        r_bus <= w_wb_word;
                    end else if (r_bus[8:7] == READ_MISS) begin
                        r_bus <= w_miss_word;
                    end
                    r_step  <= 2'b11;
                    r_done  <= 1'b1;
                    r_state <= S3;
                end
                default: begin
                    r_step  <= 2'b11;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef SNOOP_BUS_STATS_EN
    logic [15:0] r_stat_miss;
    logic [15:0] r_stat_wb;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_stat_miss <= '0;
            r_stat_wb   <= '0;
        end else begin
            if ((r_state == S2) && (r_bus[8:7] == READ_MISS) && (r_stat_miss != 16'hFFFF))
                r_stat_miss <= r_stat_miss + 16'd1;
            if (w_wb_absorb && (r_stat_wb != 16'hFFFF))
                r_stat_wb <= r_stat_wb + 16'd1;
        end
    end

    assign stat_miss = r_stat_miss;
    assign stat_wb   = r_stat_wb;
`else
    assign stat_miss = '0;
    assign stat_wb   = '0;
`endif

    assign grant       = r_grant;
    assign step        = r_step;
    assign instruction = r_instr;
    assign in_bus      = r_bus;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Self-checking bench for snoop_bus_ctrl. The bench plays the caches, keeps a
// transaction-level model (rr pointer, memory array, sticky error, counters)
// and predicts every broadcast value from the bus rules.
module tb_snoop_bus_ctrl;
    localparam int         NPROC = 2;
    localparam logic [1:0] INV = 2'b00, RM = 2'b01, WB = 2'b10, RH = 2'b11;
    localparam logic [8:0] IDLEW = 9'h180;

    logic                clock = 1'b0;
    logic                resetn = 1'b0;
    logic [NPROC-1:0]    req;
    logic [10*NPROC-1:0] instr_in;
    logic [NPROC-1:0]    grant;
    logic [1:0]          step;
    logic [9:0]          instruction;
    logic [9*NPROC-1:0]  cache_out;
    logic [8:0]          in_bus;
    logic                busy, done, err;
    logic [15:0]         stat_miss, stat_wb;

    snoop_bus_ctrl #(.NPROC(NPROC)) dut (
        .clock(clock), .resetn(resetn), .req(req), .instr_in(instr_in),
        .grant(grant), .step(step), .instruction(instruction),
        .cache_out(cache_out), .in_bus(in_bus), .busy(busy), .done(done),
        .err(err), .stat_miss(stat_miss), .stat_wb(stat_wb)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [3:0] m_mem [8];
    int         m_ptr;
    logic       m_err;
    logic [9:0] m_instr;
    logic [8:0] m_bus;
    int         m_miss, m_wb;

    logic [9:0] slot_instr [NPROC];
    logic [8:0] s0w [NPROC];
    logic [8:0] s2w [NPROC];
    logic [8:0] s1w;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic chk_stats();
`ifdef SNOOP_BUS_STATS_EN
        chk("stat_miss", 32'(stat_miss), 32'(m_miss));
        chk("stat_wb",   32'(stat_wb),   32'(m_wb));
`else
        chk("stat_miss", 32'(stat_miss), 32'd0);
        chk("stat_wb",   32'(stat_wb),   32'd0);
`endif
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = 4'h0;
        m_ptr = 0; m_err = 1'b0; m_instr = 10'h180; m_bus = IDLEW;
        m_miss = 0; m_wb = 0;
    endtask

    task automatic set_slot(input int p, input logic [9:0] v);
        slot_instr[p] = v;
        instr_in[10*p +: 10] = v;
    endtask

    task automatic drive_idle();
        for (int p = 0; p < NPROC; p++) cache_out[9*p +: 9] = IDLEW;
    endtask

    // Arbitration edge: called at a negedge whose next posedge arbitrates.
    task automatic arb_cycle(output int who);
        who = -1;
        for (int d = 0; d < NPROC; d++) begin
            int p;
            p = (m_ptr + d) % NPROC;
            if (who < 0 && req[p]) who = p;
        end
        @(negedge clock);
        if (who < 0) begin
            chk("idle_step",  32'(step), 32'h3);
            chk("idle_busy",  32'(busy), 32'h0);
            chk("idle_grant", 32'(grant), 32'h0);
            chk("idle_done",  32'(done), 32'h0);
            chk("idle_instr", 32'(instruction), 32'(m_instr));
            chk("idle_bus",   32'(in_bus), 32'(m_bus));
        end else begin
            m_instr = {slot_instr[who][9], 2'(who), slot_instr[who][6:0]};
            m_ptr   = (who + 1) % NPROC;
            chk("s0_grant", 32'(grant), 32'(1) << who);
            chk("s0_step",  32'(step), 32'h0);
            chk("s0_instr", 32'(instruction), 32'(m_instr));
            chk("s0_busy",  32'(busy), 32'h1);
            chk("s0_done",  32'(done), 32'h0);
        end
    endtask

    task automatic run_phases(input int who, input logic [NPROC-1:0] keep,
                              input bit rnd, input bit abort);
        int first, cnt;
        logic [2:0] tg;
        if (!keep[who]) req[who] = 1'b0;
        tg = m_instr[6:4];
        // S0: victim evictions
        if (rnd)
            for (int p = 0; p < NPROC; p++)
                s0w[p] = {($urandom_range(0, 7) == 0) ? WB : RH, 3'($urandom), 4'($urandom)};
        for (int p = 0; p < NPROC; p++) cache_out[9*p +: 9] = s0w[p];
        first = -1; cnt = 0;
        for (int p = 0; p < NPROC; p++)
            if (s0w[p][8:7] == WB) begin cnt++; if (first < 0) first = p; end
        if (first >= 0) begin m_mem[s0w[first][6:4]] = s0w[first][3:0]; m_wb++; end
        if (cnt > 1) m_err = 1'b1;
        m_bus = IDLEW;
        @(negedge clock);
        chk("s1_step",  32'(step), 32'h1);
        chk("s1_bus",   32'(in_bus), 32'(IDLEW));
        chk("s1_grant", 32'(grant), 32'h0);
        chk("s1_err",   32'(err), 32'(m_err));
        if (abort) begin
            #1 resetn = 1'b0;
            #1;
            m_reset();
            chk("rst_step",  32'(step), 32'h3);
            chk("rst_busy",  32'(busy), 32'h0);
            chk("rst_instr", 32'(instruction), 32'h180);
            chk("rst_bus",   32'(in_bus), 32'h180);
            chk("rst_err",   32'(err), 32'h0);
            drive_idle();
            @(negedge clock);
            resetn = 1'b1;
            return;
        end
        // S1: requester presents its bus request
        if (rnd) s1w = {m_instr[9] ? INV : ($urandom_range(0, 1) ? RM : RH), tg, 4'($urandom)};
        for (int p = 0; p < NPROC; p++)
            cache_out[9*p +: 9] = (p == who) ? s1w : {RH, 3'($urandom), 4'($urandom)};
        m_bus = s1w;
        @(negedge clock);
        chk("s2_step", 32'(step), 32'h2);
        chk("s2_bus",  32'(in_bus), 32'(m_bus));
        chk("s2_done", 32'(done), 32'h0);
        // S2: snoop responses / data supply
        if (rnd)
            for (int p = 0; p < NPROC; p++)
                s2w[p] = {(p != who && $urandom_range(0, 2) == 0) ? WB : RH, 3'($urandom), 4'($urandom)};
        for (int p = 0; p < NPROC; p++) cache_out[9*p +: 9] = s2w[p];
        if (m_bus[8:7] == RM) m_miss++;
        first = -1; cnt = 0;
        for (int p = 0; p < NPROC; p++)
            if (p != who && s2w[p][8:7] == WB) begin cnt++; if (first < 0) first = p; end
        if (cnt > 1) m_err = 1'b1;
        if (first >= 0) begin
            m_mem[s2w[first][6:4]] = s2w[first][3:0];
            m_bus = s2w[first];
            m_wb++;
        end else if (m_bus[8:7] == RM) begin
            m_bus = {RM, m_bus[6:4], m_mem[m_bus[6:4]]};
        end
        @(negedge clock);
        chk("s3_step", 32'(step), 32'h3);
        chk("s3_bus",  32'(in_bus), 32'(m_bus));
        chk("s3_done", 32'(done), 32'h1);
        chk("s3_busy", 32'(busy), 32'h1);
        chk("s3_err",  32'(err), 32'(m_err));
        chk_stats();
        drive_idle();
    endtask

    task automatic one_op(input logic [NPROC-1:0] keep, input bit rnd, input bit abort);
        int who;
        arb_cycle(who);
        if (who >= 0) run_phases(who, keep, rnd, abort);
    endtask

    task automatic idle_words();
        for (int p = 0; p < NPROC; p++) begin s0w[p] = IDLEW; s2w[p] = IDLEW; end
    endtask

    initial begin
        req = '0; instr_in = '0; drive_idle(); m_reset(); idle_words(); s1w = IDLEW;
        for (int p = 0; p < NPROC; p++) set_slot(p, 10'h0);
        repeat (3) @(negedge clock);
        chk("rst0_step",  32'(step), 32'h3);
        chk("rst0_instr", 32'(instruction), 32'h180);
        chk("rst0_bus",   32'(in_bus), 32'h180);
        chk("rst0_busy",  32'(busy), 32'h0);
        chk("rst0_grant", 32'(grant), 32'h0);
        chk("rst0_err",   32'(err), 32'h0);
        chk_stats();
        resetn = 1'b1;

        // no requests: bus stays idle
        repeat (10) one_op('0, 1'b0, 1'b0);

        // P0 read miss on tag 3; cache 1 evicts {WB,3,5} in S0 first
        set_slot(0, {1'b0, 2'b10, 3'd3, 4'h0});
        idle_words(); s0w[1] = {WB, 3'd3, 4'h5}; s1w = {RM, 3'd3, 4'h0};
        req = 2'b01; one_op('0, 1'b0, 1'b0);

        // P1 write tag 2 data A, then P0 read tag 2 supplied by P1
        set_slot(1, {1'b1, 2'b00, 3'd2, 4'hA});
        idle_words(); s1w = {INV, 3'd2, 4'hA};
        req = 2'b10; one_op('0, 1'b0, 1'b0);
        set_slot(0, {1'b0, 2'b01, 3'd2, 4'h0});
        idle_words(); s1w = {RM, 3'd2, 4'h0}; s2w[1] = {WB, 3'd2, 4'hA};
        req = 2'b01; one_op('0, 1'b0, 1'b0);

        // both held: alternate with no idle cycle
        req = 2'b11;
        repeat (4) one_op(2'b11, 1'b1, 1'b0);
        req = 2'b00; one_op('0, 1'b0, 1'b0);

        // both caches write back in S0: cache 0 wins, err sticks
        set_slot(0, {1'b0, 2'b00, 3'd5, 4'h0});
        idle_words(); s0w[0] = {WB, 3'd5, 4'h7}; s0w[1] = {WB, 3'd5, 4'h9}; s1w = {RM, 3'd5, 4'h0};
        req = 2'b01; one_op('0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            req = req | NPROC'($urandom);
            one_op('0, 1'b1, 1'b0);
        end
        req = '0; one_op('0, 1'b0, 1'b0);

        // reset during S1 with req held, then re-grant reads cleared memory
        set_slot(0, {1'b0, 2'b00, 3'd3, 4'h0});
        idle_words(); s0w[1] = {WB, 3'd4, 4'h9};
        req = 2'b01; one_op(2'b01, 1'b0, 1'b1);
        idle_words(); s1w = {RM, 3'd3, 4'h0};
        one_op('0, 1'b0, 1'b0);
        idle_words(); s1w = {RM, 3'd4, 4'h0};
        req = 2'b01; one_op('0, 1'b0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 3) == 0) set_slot($urandom_range(0, NPROC-1), 10'($urandom));
            req = req | (NPROC'($urandom) & NPROC'($urandom));
            if ($urandom_range(0, 9) == 0) req = req & NPROC'($urandom);
            one_op('0, 1'b1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
